// File: rtl/tinycpu_mem_pkg.sv
// tinycpu_mem_pkg: arbiter FSM encoding and default bus widths shared by the RAM path and its bench
package tinycpu_mem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT} arb_state_t;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester handshake plus RAM command bus; master is the environment, slave the arbiter
interface mem_arbiter_rr_if
    import tinycpu_mem_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
);
    localparam int ID_W = $clog2(NUM_PORTS);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_di;
    logic [DATA_W-1:0]           mem_do;
    modport master (
        output req, req_we, req_addr, req_wdata, mem_do,
        input  ack, rdata, grant_id, busy, mem_en, mem_we, mem_addr, mem_di
    );
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_do,
        output ack, rdata, grant_id, busy, mem_en, mem_we, mem_addr, mem_di
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: round-robin search for the first unmasked requester after the last granted port
module rr_pick #(
    parameter int NUM_PORTS = 3,
    localparam int ID_W = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [NUM_PORTS-1:0] i_mask,
    input  logic [ID_W-1:0]      i_last,
    output logic                 o_valid,
    output logic [ID_W-1:0]      o_winner
);
    logic [NUM_PORTS-1:0] w_cand;
    logic [ID_W-1:0]      w_pos;
    assign w_cand = i_req & ~i_mask;
    // walk from the farthest position to the nearest so the nearest candidate is kept last
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_pos    = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_pos = ID_W'((int'(i_last) + k) % NUM_PORTS);
            if (w_cand[w_pos]) begin
                o_valid  = 1'b1;
                o_winner = w_pos;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: serialises N requesters onto one synchronous RAM port with round-robin fairness
module mem_arbiter_rr
    import tinycpu_mem_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input logic            clk,
    input logic            reset,
    mem_arbiter_rr_if.slave io_bus
);
    localparam int ID_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    arb_state_t           r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_last, r_grant, w_win;
    logic                 r_mem_en, r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_di;
    logic                 w_done, w_arb, w_valid, w_grant, w_busy;
    logic [NUM_PORTS-1:0] w_mask, w_ack;

    assign w_done  = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_arb   = (r_state == ST_IDLE) || w_done;
    assign w_mask  = w_done ? (NUM_PORTS'(1) << r_grant) : '0;
    assign w_grant = w_arb && w_valid;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .i_req    (io_bus.req),
        .i_mask   (w_mask),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_winner (w_win)
    );

    // state register
    always_ff @(posedge clk) r_state <= reset ? ST_IDLE : w_next;

    // one command cycle, then wait out the read latency and re-arbitrate on completion
    always_comb begin
        w_next = (r_state == ST_CMD) ? ST_WAIT : w_arb ? (w_valid ? ST_CMD : ST_IDLE) : r_state;
    end

    // completion pulse for the port in flight; suppressed while reset aborts the access
    always_comb begin
        w_ack  = (w_done && !reset) ? (NUM_PORTS'(1) << r_grant) : '0;
        w_busy = (r_state != ST_IDLE);
    end

    // latency counter, grant bookkeeping and the RAM command, which is zero outside its cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_last     <= ID_W'(NUM_PORTS - 1);
            r_grant    <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_di   <= '0;
        end else begin
            r_cnt      <= (r_state == ST_CMD) ? CNT_LOAD : (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
            r_mem_en   <= w_grant;
            r_mem_we   <= w_grant && io_bus.req_we[w_win];
            r_mem_addr <= w_grant ? io_bus.req_addr[w_win*ADDR_W +: ADDR_W] : '0;
            r_mem_di   <= w_grant ? io_bus.req_wdata[w_win*DATA_W +: DATA_W] : '0;
            if (w_grant) begin
                r_last  <= w_win;
                r_grant <= w_win;
            end
        end
    end

    assign io_bus.ack      = w_ack;
    assign io_bus.rdata    = io_bus.mem_do;
    assign io_bus.grant_id = r_grant;
    assign io_bus.busy     = w_busy;
    assign io_bus.mem_en   = r_mem_en;
    assign io_bus.mem_we   = r_mem_we;
    assign io_bus.mem_addr = r_mem_addr;
    assign io_bus.mem_di   = r_mem_di;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed and randomized checks of the round-robin RAM arbiter against a transaction model
module tb_mem_arbiter_rr;
    import tinycpu_mem_pkg::*;
    localparam int N    = 3;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut1 (
        .clk(clk), .reset(reset), .io_bus(bus1)
    );
    mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT3)) dut3 (
        .clk(clk), .reset(reset), .io_bus(bus3)
    );

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : 8'(a * 8'd37 + 8'd11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM behind dut1: single-cycle read latency, unwritten words read their initial pattern
    logic [7:0] ram1 [256];
    bit         wr1  [256];
    always @(posedge clk) begin
        if (bus1.mem_en) begin
            if (bus1.mem_we) begin
                ram1[bus1.mem_addr] <= bus1.mem_di;
                wr1[bus1.mem_addr]  <= 1'b1;
            end
            bus1.mem_do <= wr1[bus1.mem_addr] ? ram1[bus1.mem_addr] : init_val(bus1.mem_addr);
        end
    end

    // read-only RAM behind dut3 with a three-stage read pipeline
    logic [7:0] pipe3 [LAT3];
    always @(posedge clk) begin
        if (bus3.mem_en) pipe3[0] <= init_val(bus3.mem_addr);
        for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
    end
    assign bus3.mem_do = pipe3[LAT3-1];

    // transaction model of dut1: cycles remaining until ack, port in flight, rotation pointer
    int         m_rem = 0;
    int         m_port = 0;
    int         m_last = N - 1;
    int         m_gid = 0;
    bit         m_on = 1'b0;
    logic       m_we = 1'b0;
    logic [7:0] m_addr = '0;
    logic [7:0] m_wd = '0;
    logic [7:0] ref_mem [256];
    bit         ref_wr  [256];

    always @(negedge clk) begin
        logic [N-1:0] e_ack;
        logic         e_en;
        int           pick;
        int           p;
        if (m_on) begin
            e_en  = (m_rem == LAT + 1);
            e_ack = (m_rem == 1 && !reset) ? N'(1 << m_port) : '0;
            chk("m_busy", bus1.busy, m_rem != 0);
            chk("m_mem_en", bus1.mem_en, e_en);
            chk("m_mem_we", bus1.mem_we, e_en ? m_we : 1'b0);
            chk("m_mem_addr", bus1.mem_addr, e_en ? m_addr : 8'h00);
            chk("m_mem_di", bus1.mem_di, e_en ? m_wd : 8'h00);
            chk("m_ack", bus1.ack, e_ack);
            chk("m_grant_id", bus1.grant_id, m_gid);
            if (e_ack != 0 && !m_we)
                chk("m_rdata", bus1.rdata, ref_wr[m_addr] ? ref_mem[m_addr] : init_val(m_addr));
        end
        if (reset) begin
            m_on = 1'b1; m_rem = 0; m_last = N - 1; m_gid = 0;
        end else begin
            pick = -1;
            if (m_rem <= 1)
                for (int k = 1; k <= N; k++) begin
                    p = (m_last + k) % N;
                    if (pick < 0 && bus1.req[p] && !(m_rem == 1 && p == m_port)) pick = p;
                end
            if (pick >= 0) begin
                m_rem = LAT + 1; m_port = pick; m_last = pick; m_gid = pick;
                m_we   = bus1.req_we[pick];
                m_addr = bus1.req_addr[pick*AW +: AW];
                m_wd   = bus1.req_wdata[pick*DW +: DW];
                if (m_we) begin
                    ref_mem[m_addr] = m_wd;
                    ref_wr[m_addr]  = 1'b1;
                end
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus1.req = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus3.req = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_port(input int p, input bit r, input bit we, input logic [7:0] a, input logic [7:0] d);
        bus1.req[p]              = r;
        bus1.req_we[p]           = we;
        bus1.req_addr[p*AW +: AW] = a;
        bus1.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic wait_ack(input int p, input int budget, output int n);
        n = 0;
        @(negedge clk);
        while (!bus1.ack[p] && n < budget) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("ack_in_budget", bus1.ack[p], 1);
    endtask

    logic [2:0] exp_rot  [9] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    logic [2:0] exp_ack3 [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100};
    logic       exp_en3  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] acked;

    initial begin
        int n, acc, p1cnt;
        bit done;
        do_reset();
        // single read: reset values, command at cycle 1, ack with data at cycle 2
        set_port(0, 1, 0, 8'h10, 8'h00);
        @(negedge clk);
        chk("rst_grant_id", bus1.grant_id, 0);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_mem_en", bus1.mem_en, 0);
        chk("rst_mem_addr", bus1.mem_addr, 0);
        chk("rst_ack", bus1.ack, 0);
        tick(); @(negedge clk);
        chk("t1_mem_en", bus1.mem_en, 1);
        chk("t1_mem_addr", bus1.mem_addr, 8'h10);
        chk("t1_busy_c1", bus1.busy, 1);
        tick(); @(negedge clk);
        chk("t1_ack", bus1.ack, 3'b001);
        chk("t1_rdata", bus1.rdata, 8'hA5);
        chk("t1_busy_c2", bus1.busy, 1);
        tick(); bus1.req = '0; @(negedge clk);
        chk("t1_idle", bus1.busy, 0);
        // all ports held: rotation 001,010,100,001 every two cycles
        do_reset();
        bus1.req = 3'b111;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("t2_rot", bus1.ack, exp_rot[c]);
            tick();
        end
        // write by port 1 then read back by port 2
        do_reset();
        set_port(1, 1, 1, 8'h20, 8'h3C);
        wait_ack(1, 10, n);
        chk("t3_wr_lat", n, 2);
        tick();
        set_port(1, 0, 0, 8'h00, 8'h00);
        set_port(2, 1, 0, 8'h20, 8'h00);
        wait_ack(2, 10, n);
        chk("t3_rd_lat", n, 2);
        chk("t3_rdata", bus1.rdata, 8'h3C);
        tick(); bus1.req = '0;
        // port 0 continuous, port 2 once: port 2 served at the very next arbitration
        do_reset();
        set_port(0, 1, 0, 8'h01, 8'h00);
        tick();
        set_port(2, 1, 0, 8'h02, 8'h00);
        acc = 0; p1cnt = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus1.ack != 0) acc++;
            if (bus1.ack[1]) p1cnt++;
            done = bus1.ack[2];
            tick();
        end
        chk("t4_served", done, 1);
        chk("t4_accesses", acc, 2);
        set_port(2, 0, 0, 8'h00, 8'h00);
        repeat (10) begin
            @(negedge clk);
            if (bus1.ack[1]) p1cnt++;
            tick();
        end
        chk("t4_p1_never", p1cnt, 0);
        // reset during the ack cycle of port 1 aborts it; port 0 then wins first
        do_reset();
        set_port(1, 1, 0, 8'h05, 8'h00);
        tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_no_ack", bus1.ack, 0);
        tick();
        reset = 1'b0;
        bus1.req = 3'b111;
        @(negedge clk);
        chk("t5_mem_en_off", bus1.mem_en, 0);
        chk("t5_busy_off", bus1.busy, 0);
        tick(); @(negedge clk);
        chk("t5_mem_en_on", bus1.mem_en, 1);
        chk("t5_first_port0", bus1.grant_id, 0);
        tick(); bus1.req = '0;
        // latency 3: command at cycle 1, acks at cycles 4 and 8
        do_reset();
        bus3.req = 3'b110;
        bus3.req_addr = {8'h44, 8'h33, 8'h00};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("t6_ack", bus3.ack, exp_ack3[c]);
            chk("t6_mem_en", bus3.mem_en, exp_en3[c]);
            if (c == 4) chk("t6_rdata1", bus3.rdata, init_val(8'h33));
            if (c == 8) chk("t6_rdata2", bus3.rdata, init_val(8'h44));
            tick();
        end
        bus3.req = '0;
        // randomized traffic with occasional resets and field scrambling while in flight
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acked = bus1.ack;
            tick();
            reset = ($urandom_range(0, 399) == 0);
            for (int p = 0; p < N; p++) begin
                if (acked[p] || (!bus1.req[p] && $urandom_range(0, 3) == 0))
                    set_port(p, (acked[p] ? 1'($urandom_range(0, 1)) : 1'b1), 1'($urandom_range(0, 1)),
                             8'($urandom_range(0, 7)), 8'($urandom));
                else if (bus1.req[p] && m_rem > 0 && m_port == p)
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            end
        end
        reset = 1'b0;
        bus1.req = '0;
        repeat (6) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end
endmodule
